// File: rtl/uart_tx_fifo_cfg.sv
// UART transmitter with input FIFO, DATA_W-bit LSB-first frames and 1/2 stop bits.
// Define UART_TX_PARITY_EN to add the i_parity_mode port and the parity bit.
module uart_tx_fifo_cfg #(
  parameter int DATA_W       = 8,
  parameter int TICK_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          i_Clock,
  input  logic                          i_reset,
  input  logic                          i_enable,
  input  logic                          i_tick,
  input  logic                          i_valid,
  input  logic [DATA_W-1:0]             i_data,
  output logic                          o_ready,
  input  logic                          i_stop2,
`ifdef UART_TX_PARITY_EN
  input  logic [1:0]                    i_parity_mode,
`endif
  output logic                          o_TX,
  output logic                          o_TX_Active,
  output logic                          o_TX_Done,
  output logic [$clog2(FIFO_DEPTH):0]   o_fifo_count
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(TICK_PER_BIT);
  localparam int BW = $clog2(DATA_W);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_PER_BIT - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
    S_PARITY = 3'd3,
`endif
    S_STOP   = 3'd4
  } state_t;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  logic              push, pop;

  state_t            state_q, state_d;
  logic [TW-1:0]     tick_q, tick_d;
  logic [BW-1:0]     bit_q, bit_d;
  logic              stop2_q, stop2_d;
  logic              tx_q, tx_d;
  logic              active_q, active_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] shreg_q, shreg_d;
  logic              bit_end;
`ifdef UART_TX_PARITY_EN
  logic              par_en_q, par_en_d;
  logic              par_bit_q, par_bit_d;
`endif

  // Full is judged on the registered count, so a same-cycle pop never frees a slot early.
  assign o_ready = (count_q != CW'(FIFO_DEPTH));
  assign push    = i_valid && o_ready;
  assign bit_end = i_tick && (tick_q == TICK_LAST);

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge i_Clock) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
    shreg_q <= shreg_d;
  end

  always_ff @(posedge i_Clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q   <= S_IDLE;
      tick_q    <= '0;
      bit_q     <= '0;
      stop2_q   <= 1'b0;
      tx_q      <= 1'b1;
      active_q  <= 1'b0;
      done_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      tick_q    <= tick_d;
      bit_q     <= bit_d;
      stop2_q   <= stop2_d;
      tx_q      <= tx_d;
      active_q  <= active_d;
      done_q    <= done_d;
`ifdef UART_TX_PARITY_EN
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    tick_d    = tick_q;
    bit_d     = bit_q;
    stop2_d   = stop2_q;
    tx_d      = tx_q;
    active_d  = active_q;
    done_d    = 1'b0;
    shreg_d   = shreg_q;
    pop       = 1'b0;
`ifdef UART_TX_PARITY_EN
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
`endif
    if (i_enable) begin
      if (state_q != S_IDLE && i_tick) tick_d = bit_end ? '0 : tick_q + 1'b1;
      case (state_q)
        S_IDLE: begin
          tx_d = 1'b1;
          if (count_q != '0) begin
            pop      = 1'b1;
            shreg_d  = mem_q[rd_ptr_q];
            stop2_d  = i_stop2;
`ifdef UART_TX_PARITY_EN
            par_en_d  = (i_parity_mode == 2'b01) || (i_parity_mode == 2'b10);
            par_bit_d = (^mem_q[rd_ptr_q]) ^ (i_parity_mode == 2'b10);
`endif
            tx_d     = 1'b0;
            active_d = 1'b1;
            tick_d   = '0;
            state_d  = S_START;
          end
        end
        S_START: if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
        S_DATA: if (bit_end) begin
          if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
            if (par_en_q) begin
              state_d = S_PARITY;
              tx_d    = par_bit_q;
            end else
`endif
            begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              bit_d   = '0;
            end
          end else begin
            bit_d   = bit_q + 1'b1;
            shreg_d = shreg_q >> 1;
            tx_d    = shreg_q[1];
          end
        end
`ifdef UART_TX_PARITY_EN
        S_PARITY: if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          bit_d   = '0;
        end
`endif
        S_STOP: if (bit_end) begin
          if (stop2_q && bit_q == '0) begin
            bit_d = BW'(1);
          end else begin
            done_d   = 1'b1;
            active_d = 1'b0;
            state_d  = S_IDLE;
          end
        end
        default: begin
          state_d  = S_IDLE;
          tx_d     = 1'b1;
          active_d = 1'b0;
          tick_d   = '0;
        end
      endcase
    end
  end

  always_comb begin
    o_TX         = tx_q;
    o_TX_Active  = active_q;
    o_TX_Done    = done_q && i_enable;
    o_fifo_count = count_q;
  end

endmodule

// File: tb/tb_uart_tx_fifo_cfg.sv
// Scoreboard bench for uart_tx_fifo_cfg: expected frames queued at push time,
// a line monitor decodes each frame and compares it with a frame-level model.
module tb_uart_tx_fifo_cfg;

  logic       clk = 1'b0;
  logic       i_reset = 1'b0;
  logic       i_enable = 1'b1;
  logic       i_tick = 1'b1;
  logic       i_valid = 1'b0;
  logic [7:0] i_data = '0;
  logic       i_stop2 = 1'b0;
  logic [1:0] pm = 2'b00;
  logic       o_ready, o_TX, o_TX_Active, o_TX_Done;
  logic [2:0] o_fifo_count;

  uart_tx_fifo_cfg #(.DATA_W(8), .TICK_PER_BIT(16), .FIFO_DEPTH(4)) dut (
    .i_Clock      (clk),
    .i_reset      (i_reset),
    .i_enable     (i_enable),
    .i_tick       (i_tick),
    .i_valid      (i_valid),
    .i_data       (i_data),
    .o_ready      (o_ready),
    .i_stop2      (i_stop2),
`ifdef UART_TX_PARITY_EN
    .i_parity_mode(pm),
`endif
    .o_TX         (o_TX),
    .o_TX_Active  (o_TX_Active),
    .o_TX_Done    (o_TX_Done),
    .o_fifo_count (o_fifo_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit [7:0] word;
    bit       stop2;
    bit [1:0] pmode;
    int       extra;
    bit       b2b;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, req, $time);
    end
  endtask

  // Frame model: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits.
  function automatic bit par_on(exp_t e);
    return (e.pmode == 2'b01) || (e.pmode == 2'b10);
  endfunction

  function automatic int nbits(exp_t e);
    return 1 + 8 + (par_on(e) ? 1 : 0) + (e.stop2 ? 2 : 1);
  endfunction

  function automatic bit exp_bit(exp_t e, int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return e.word[k-1];
    if (par_on(e) && k == 9) return (e.pmode == 2'b01) ? ^e.word : ~^e.word;
    return 1'b1;
  endfunction

  // Monitor: samples at negedge, counts only intervals whose closing edge is enabled.
  exp_t cur;
  bit   in_frame = 1'b0;
  int   en_cnt, tot_cnt, bad_k;
  int   gap = 1000;

  always @(negedge clk) begin
    if (!i_reset) begin
      in_frame = 1'b0;
      sb.delete();
      gap = 1000;
    end else if (o_TX_Active) begin
      if (!in_frame) begin
        if (sb.size() == 0) begin
          chk("unexpected_frame", 1, 0);
          cur = '{default: 0};
        end else begin
          cur = sb.pop_front();
          if (cur.b2b) chk("b2b_gap", gap, 1);
        end
        in_frame = 1'b1;
        en_cnt = 0;
        tot_cnt = 0;
        bad_k = -1;
      end
      tot_cnt++;
      if (i_enable) begin
        if (bad_k < 0 && o_TX !== exp_bit(cur, en_cnt / 16)) bad_k = en_cnt;
        en_cnt++;
      end
    end else begin
      if (in_frame) begin
        in_frame = 1'b0;
        chk("frame_bits_first_bad_sample", bad_k, -1);
        chk("frame_len_enabled", en_cnt, 16 * nbits(cur));
        chk("frame_len_total", tot_cnt, 16 * nbits(cur) + cur.extra);
        chk("done_pulse", int'(o_TX_Done), 1);
        gap = 1;
      end else begin
        if (o_TX_Done) chk("spurious_done", 1, 0);
        if (gap < 1000) gap++;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [7:0] w, input int extra, input bit b2b);
    exp_t e;
    e.word = w;
    e.stop2 = i_stop2;
    e.pmode = pm;
    e.extra = extra;
    e.b2b = b2b;
    sb.push_back(e);
    i_valid = 1'b1;
    i_data = w;
    tick();
    i_valid = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc);
    int n;
    n = 0;
    while (!(sb.size() == 0 && !in_frame && o_fifo_count == 0) && n < max_cyc) begin
      tick();
      n++;
    end
    if (n >= max_cyc) chk("wait_idle_timeout", n, 0);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int seen_done, seen_low;
    exp_t dummy;
    repeat (3) tick();
    chk("rst_tx", int'(o_TX), 1);
    chk("rst_active", int'(o_TX_Active), 0);
    chk("rst_done", int'(o_TX_Done), 0);
    chk("rst_ready", int'(o_ready), 1);
    chk("rst_count", int'(o_fifo_count), 0);
    i_reset = 1'b1;
    repeat (2) tick();

    // Frame 0xA5, no parity, one stop bit
    push(8'hA5, 0, 1'b0);
    wait_idle(400);

    // Parity and two-stop frames
`ifdef UART_TX_PARITY_EN
    pm = 2'b01; push(8'h07, 0, 1'b0); wait_idle(400);
    pm = 2'b10; i_stop2 = 1'b1; push(8'h07, 0, 1'b0); wait_idle(400);
    pm = 2'b00;
`endif
    i_stop2 = 1'b1; push(8'h3C, 0, 1'b0); wait_idle(400);
    i_stop2 = 1'b0;

    // Fill FIFO while disabled, 5th push dropped, then drain back-to-back
    i_enable = 1'b0;
    for (int i = 0; i < 4; i++) push(8'($urandom), 0, i != 0);
    chk("full_count", int'(o_fifo_count), 4);
    chk("full_ready", int'(o_ready), 0);
    i_valid = 1'b1; i_data = 8'hFF; tick(); i_valid = 1'b0;
    chk("drop_count", int'(o_fifo_count), 4);
    chk("no_tx_while_disabled", int'(o_TX_Active), 0);
    i_enable = 1'b1;
    tick();
    chk("ready_after_pop", int'(o_ready), 1);
    chk("count_after_pop", int'(o_fifo_count), 3);
    wait_idle(1500);

    // Freeze 50 clocks mid-DATA
    push(8'($urandom), 50, 1'b0);
    repeat (64) tick();
    i_enable = 1'b0;
    repeat (50) tick();
    i_enable = 1'b1;
    wait_idle(400);

    // Reset mid-DATA with a second word queued
    push(8'($urandom), 0, 1'b0);
    push(8'($urandom), 0, 1'b1);
    repeat (58) tick();
    #2;
    i_reset = 1'b0;
    #1;
    chk("midrst_tx", int'(o_TX), 1);
    chk("midrst_count", int'(o_fifo_count), 0);
    chk("midrst_active", int'(o_TX_Active), 0);
    repeat (2) tick();
    i_reset = 1'b1;
    seen_done = 0;
    seen_low = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (o_TX_Done) seen_done++;
      if (!o_TX) seen_low++;
    end
    chk("post_rst_done", seen_done, 0);
    chk("post_rst_tx_low", seen_low, 0);
    chk("post_rst_count", int'(o_fifo_count), 0);

    // Config changes mid-frame apply only to the next frame
    i_stop2 = 1'b0;
`ifdef UART_TX_PARITY_EN
    pm = 2'b01;
`endif
    push(8'($urandom), 0, 1'b0);
    repeat (40) tick();
    i_stop2 = 1'b1;
`ifdef UART_TX_PARITY_EN
    pm = 2'b10;
`endif
    push(8'($urandom), 0, 1'b1);
    wait_idle(800);

    // Randomised single frames, then a back-to-back burst
    for (int i = 0; i < 6; i++) begin
      i_stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
      pm = 2'($urandom_range(0, 3));
`endif
      push(8'($urandom), 0, 1'b0);
      wait_idle(400);
    end
    i_stop2 = 1'($urandom_range(0, 1));
`ifdef UART_TX_PARITY_EN
    pm = 2'($urandom_range(0, 3));
`endif
    for (int i = 0; i < 3; i++) push(8'($urandom), 0, i != 0);
    wait_idle(1500);

    dummy = '{default: 0};
    chk("sb_drained", sb.size(), 0);
    chk("model_len_sanity", nbits(dummy), 10);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
